// File: rtl/instr_loader_if.sv
// Loader bus: byte stream into the loader and the queue write port out of it.
// master = loader side, slave = stream source / queue side.
interface instr_loader_if #(
   parameter int INSTR_W = 39,
   parameter int ADDR_W  = 6
);
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_last;
   logic               byte_ready;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [INSTR_W-1:0] wr_data;

   modport master (
      input  byte_in, byte_valid, byte_last,
      output byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output byte_in, byte_valid, byte_last,
      input  byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/instr_loader.sv
// NuCore instruction queue writer: packs little-endian bytes into words.
// Define INSTR_LOADER_CHECKSUM_EN for 6-byte framing with an XOR checksum.
module instr_loader #(
   parameter int INSTR_W = 39,
   parameter int ADDR_W  = 6,
   parameter int DEPTH   = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   instr_loader_if.master  bus,
   output logic            busy,
   output logic            done,
   output logic [ADDR_W:0] word_count,
   output logic            err_format,
   output logic            err_overflow
);
`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd5;
`else
   localparam logic [2:0] LAST_IDX = 3'd4;
`endif
   localparam int TOP_W = INSTR_W - 32;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [INSTR_W-1:0] word_q, word_d;
   logic               fmt_q, fmt_d;
   logic               ovf_q, ovf_d;
   logic               last_q, last_d;
   logic               accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]         sum_q, sum_d;
`endif

   // start outranks a byte offered in the same cycle
   assign accept = bus.byte_valid && (state_q == S_LOAD) && !start;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      fmt_d   = fmt_q;
      ovf_d   = ovf_q;
      last_d  = last_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            idx_d  = '0;
            addr_d = '0;
            cnt_d  = '0;
            fmt_d  = 1'b0;
            ovf_d  = 1'b0;
         end
         S_LOAD: begin
            if (accept) begin
               for (int k = 0; k < 4; k++) begin
                  if (idx_q == 3'(k)) word_d[8*k +: 8] = bus.byte_in;
               end
               // top byte carries only TOP_W bits; anything above is illegal
               if (idx_q == 3'd4) begin
                  word_d[INSTR_W-1:32] = bus.byte_in[TOP_W-1:0];
                  if (|bus.byte_in[7:TOP_W]) fmt_d = 1'b1;
               end
`ifdef INSTR_LOADER_CHECKSUM_EN
               if (idx_q == 3'd0) sum_d = bus.byte_in;
               else               sum_d = sum_q ^ bus.byte_in;
`endif
               if (idx_q == LAST_IDX) begin
                  last_d  = bus.byte_last;
                  state_d = S_WRITE;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  if (bus.byte_in != sum_q) begin
                     fmt_d   = 1'b1;
                     idx_d   = '0;
                     state_d = S_DONE;
                  end
`endif
               end else if (bus.byte_last) begin
                  fmt_d   = 1'b1;
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_WRITE: begin
            idx_d = '0;
            cnt_d = cnt_q + CNT_ONE;
            if (last_q) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_MAX) begin
               ovf_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
         end
      endcase
      if (start) begin
         state_d = S_LOAD;
         idx_d   = '0;
         addr_d  = '0;
         cnt_d   = '0;
         fmt_d   = 1'b0;
         ovf_d   = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         fmt_q   <= 1'b0;
         ovf_q   <= 1'b0;
         last_q  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         fmt_q   <= fmt_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // an aborting start squashes the write in flight
   assign bus.wr_en      = (state_q == S_WRITE) && !start;
   assign bus.wr_addr    = addr_q;
   assign bus.wr_data    = word_q;
   assign bus.byte_ready = (state_q == S_LOAD);
   assign busy           = (state_q == S_LOAD) || (state_q == S_WRITE);
   assign done           = (state_q == S_DONE);
   assign word_count     = cnt_q;
   assign err_format     = fmt_q;
   assign err_overflow   = ovf_q;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a byte-stream reference model.
// Honours INSTR_LOADER_CHECKSUM_EN for 6-byte framing.
module tb_instr_loader;
   localparam int INSTR_W = 39;
   localparam int ADDR_W  = 6;
   localparam int DEPTH   = 64;
`ifdef INSTR_LOADER_CHECKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif

   typedef struct {
      logic [ADDR_W-1:0]  a;
      logic [INSTR_W-1:0] d;
   } wr_t;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            busy, done, err_format, err_overflow;
   logic [ADDR_W:0] word_count;

   instr_loader_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

   instr_loader #(
      .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .bus         (bus.master),
      .busy        (busy),
      .done        (done),
      .word_count  (word_count),
      .err_format  (err_format),
      .err_overflow(err_overflow)
   );

   always #5 clock = ~clock;

   int         n_cmp = 0;
   int         n_bad = 0;
   wr_t        obs[$];
   wr_t        exp_w[$];
   int         acc_cnt = 0;
   bit         exp_fmt, exp_ovf;
   int         exp_acc;
   logic [7:0] prog_q[$];
   logic [7:0] pre_q[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // monitor: writes, write latency/width, and accepted byte count
   initial begin
      bit prev_acc = 0;
      bit prev_wr = 0;
      forever begin
         @(negedge clock);
         if (bus.wr_en === 1'b1) begin
            obs.push_back('{bus.wr_addr, bus.wr_data});
            chk("wr_latency", 64'(prev_acc), 1);
            chk("wr_one_cycle", 64'(prev_wr), 0);
            chk("ready_in_write", 64'(bus.byte_ready), 0);
         end
         prev_acc = (bus.byte_valid && bus.byte_ready && !start);
         if (prev_acc) acc_cnt++;
         prev_wr = (bus.wr_en === 1'b1);
      end
   end

   // reference: walk the byte stream frame by frame
   task automatic model(input logic [7:0] q[$]);
      int i = 0;
      int n = q.size();
      exp_w.delete();
      exp_fmt = 0;
      exp_ovf = 0;
      exp_acc = 0;
      forever begin
         logic [39:0] w;
         logic [7:0]  x;
         if (n - i < NB) begin
            exp_fmt = 1;
            exp_acc += n - i;
            break;
         end
         exp_acc += NB;
         w = '0;
         x = '0;
         for (int b = 0; b < 5; b++) begin
            w = w | (40'(q[i+b]) << (8 * b));
            x = x ^ q[i+b];
         end
         if (w[39]) exp_fmt = 1;
         if (NB == 6 && x != q[i+NB-1]) begin
            exp_fmt = 1;
            break;
         end
         exp_w.push_back('{ADDR_W'(exp_w.size()), w[38:0]});
         i += NB;
         if (i == n) break;
         if (exp_w.size() == DEPTH) begin
            exp_ovf = 1;
            break;
         end
      end
   endtask

   task automatic add_word(input logic [39:0] w, input bit bad_sum);
      logic [7:0] x = '0;
      for (int b = 0; b < 5; b++) begin
         prog_q.push_back(w[8*b +: 8]);
         x = x ^ w[8*b +: 8];
      end
      if (NB == 6) prog_q.push_back(bad_sum ? ~x : x);
   endtask

   task automatic send_bytes(input logic [7:0] q[$], input bit with_last,
                             output bit ok);
      int  k = 0;
      int  budget = 30 * q.size() + 50;
      bit  holding = 0;
      bit  acc, stop;
      ok = 1;
      while (k < q.size()) begin
         if (!holding && $urandom_range(3) == 0) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            bus.byte_last  = 1'($urandom);
         end else begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = q[k];
            bus.byte_last  = with_last && (k == q.size() - 1);
         end
         @(negedge clock);
         acc  = bus.byte_valid && bus.byte_ready;
         stop = done;
         @(posedge clock);
         #1;
         if (acc) k++;
         holding = bus.byte_valid && !acc;
         if (stop && !acc) break;
         budget--;
         if (budget == 0) begin
            ok = 0;
            break;
         end
      end
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start          = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'($urandom);
      bus.byte_last  = 1'($urandom);
      @(posedge clock);
      #1;
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
   endtask

   task automatic run_load(input string tag);
      bit ok;
      int t;
      model(prog_q);
      obs.delete();
      acc_cnt = 0;
      pulse_start();
      if (pre_q.size() > 0) begin
         send_bytes(pre_q, 1'b0, ok);
         chk({tag, " pre_timeout"}, 64'(ok), 1);
         pulse_start();
      end
      send_bytes(prog_q, 1'b1, ok);
      chk({tag, " timeout"}, 64'(ok), 1);
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!done && t < 20);
      chk({tag, " done"}, 64'(done), 1);
      chk({tag, " busy"}, 64'(busy), 0);
      chk({tag, " ready"}, 64'(bus.byte_ready), 0);
      chk({tag, " count"}, 64'(word_count), 64'(exp_w.size()));
      chk({tag, " err_fmt"}, 64'(err_format), 64'(exp_fmt));
      chk({tag, " err_ovf"}, 64'(err_overflow), 64'(exp_ovf));
      chk({tag, " accepted"}, 64'(acc_cnt), 64'(pre_q.size() + exp_acc));
      chk({tag, " writes"}, 64'(obs.size()), 64'(exp_w.size()));
      for (int i = 0; i < obs.size() && i < exp_w.size(); i++) begin
         chk($sformatf("%s wr%0d addr", tag, i), 64'(obs[i].a), 64'(exp_w[i].a));
         chk($sformatf("%s wr%0d data", tag, i), 64'(obs[i].d), 64'(exp_w[i].d));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      #12;
      chk("rst busy", 64'(busy), 0);
      chk("rst done", 64'(done), 0);
      chk("rst ready", 64'(bus.byte_ready), 0);
      chk("rst wr_en", 64'(bus.wr_en), 0);
      chk("rst data", 64'(bus.wr_data), 0);
      chk("rst count", 64'(word_count), 0);
      chk("rst errs", 64'({err_format, err_overflow}), 0);
      #5 reset = 1'b1;
      @(posedge clock);
      #1;

      prog_q.delete(); pre_q.delete();
      add_word(40'h0504030201, 0);
      add_word(40'h5544332211, 0);
      run_load("two_word");
      if (obs.size() >= 2) begin
         chk("two_word d0", 64'(obs[0].d), 64'h0504030201);
         chk("two_word d1", 64'(obs[1].d), 64'h5544332211);
      end

      prog_q.delete();
      add_word(40'h8504030201, 0);
      run_load("fmt_bit7");
      if (obs.size() >= 1) chk("fmt_bit7 top", 64'(obs[0].d[38:32]), 64'h05);

      prog_q.delete();
      prog_q = '{8'h10, 8'h20, 8'h30};
      run_load("last_b2");

      prog_q.delete();
      for (int w = 0; w < DEPTH + 1; w++)
         add_word({1'b0, 39'({$urandom, $urandom})}, 0);
      run_load("overflow");

      prog_q.delete();
      pre_q = '{8'hAA, 8'hBB, 8'hCC};
      add_word(40'h0102030405, 0);
      run_load("abort_load");

      pre_q.delete();
      for (int b = 0; b < NB; b++) pre_q.push_back(8'($urandom_range(127)));
      run_load("abort_write");

`ifdef INSTR_LOADER_CHECKSUM_EN
      prog_q.delete(); pre_q.delete();
      add_word(40'h0504030201, 0);
      run_load("csum_good");
      prog_q[5] = 8'h00;
      run_load("csum_bad");
`endif

      // asynchronous reset in the middle of a load
      prog_q.delete(); pre_q.delete();
      add_word(40'h8511223344, 0);
      prog_q.push_back(8'h66);
      pulse_start();
      send_bytes(prog_q, 1'b0, ok);
      chk("mid_rst timeout", 64'(ok), 1);
      @(negedge clock);
      chk("mid_rst pre count", 64'(word_count), 1);
      chk("mid_rst pre fmt", 64'(err_format), 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst busy", 64'(busy), 0);
      chk("mid_rst ready", 64'(bus.byte_ready), 0);
      chk("mid_rst count", 64'(word_count), 0);
      chk("mid_rst fmt", 64'(err_format), 0);
      chk("mid_rst addr", 64'(bus.wr_addr), 0);
      chk("mid_rst data", 64'(bus.wr_data), 0);
      #4 reset = 1'b1;
      @(posedge clock);
      #1;

      for (int r = 0; r < 30; r++) begin
         int nw = $urandom_range(1, 4);
         prog_q.delete();
         pre_q.delete();
         for (int w = 0; w < nw; w++) begin
            logic [39:0] v = {$urandom, $urandom};
            if ($urandom_range(7) != 0) v[39] = 1'b0;
            add_word(v, $urandom_range(5) == 0);
         end
         if ($urandom_range(3) == 0) begin
            int extra = $urandom_range(1, NB - 1);
            for (int b = 0; b < extra; b++) prog_q.push_back(8'($urandom));
         end
         if ($urandom_range(2) == 0) begin
            int np = $urandom_range(1, NB);
            for (int b = 0; b < np; b++) pre_q.push_back(8'($urandom));
         end
         run_load($sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program writer for the NuCore instruction queue.
- Accepts a byte stream over a valid/ready handshake and packs 5 little-endian bytes into one 39-bit instruction word.
- Writes each word to consecutive queue addresses starting at 0. This is the write side of the queue that the program counter and decoder read from.
- Signals completion on an end-of-program marker and flags malformed or overflowing streams.

Parameters:
- INSTR_W, 39, instruction word width; bits [38:36] are the ALU opcode.
- ADDR_W, 6, queue address width; matches the program counter width.
- DEPTH, 64, number of queue entries; must be at most 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new program load at address 0.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_last  in  1  byte is the final byte of the program; qualified by byte_valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  one-cycle queue write strobe.
- wr_addr  out  ADDR_W  queue write address.
- wr_data  out  INSTR_W  packed instruction word.
- busy  out  1  high in LOAD or WRITE.
- done  out  1  load finished; held until start or reset.
- word_count  out  ADDR_W+1  number of words written in the current load.
- err_format  out  1  sticky; malformed stream.
- err_overflow  out  1  sticky; program exceeds DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Byte index, address and word_count go to 0; wr_data goes to 0.
  - wr_en, byte_ready, busy, done and both error flags go to 0.
- States: IDLE, LOAD, WRITE, DONE.
- Handshake:
  - A byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_ready=1 only in LOAD.
  - byte_valid with byte_ready=0 is ignored; the sender must hold the byte.
- Packing: accepted byte k (0..4) goes to word bits [8k+7:8k]. Byte 4 bit 7 has no home in the 39-bit word, so it must be 0; if it is 1, err_format is set and the word is still written with that bit dropped.
- IDLE:
  - start moves to LOAD.
  - Clears byte index, address, word_count and both error flags.
- LOAD:
  - Each accepted byte increments the byte index.
  - On acceptance of byte 4, the next state is WRITE.
  - byte_last on bytes 0..3: set err_format, discard the partial word, go to DONE.
- WRITE (exactly one cycle):
  - wr_en=1 with wr_addr = current address and wr_data = packed word.
  - byte_ready=0; byte index clears; word_count increments.
  - If the completing byte carried byte_last: go to DONE.
  - Else if address = DEPTH-1: set err_overflow and go to DONE.
  - Else: address increments and the state returns to LOAD.
- Latency: wr_en asserts the cycle after byte 4 is accepted. Maximum throughput is 1 word per 6 cycles.
- DONE:
  - done=1, busy=0.
  - start moves to LOAD with all counters and flags cleared.
- start while in LOAD or WRITE:
  - Abort the current load and restart at address 0.
  - Discard the partial word.
  - If start coincides with a WRITE cycle, that write is suppressed (wr_en=0).
- start and an accepted byte in the same cycle: start wins and the byte is dropped.
- Reset mid-load: immediate return to IDLE with all outputs cleared. Queue contents already written are not touched.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - Each instruction is 6 bytes: 5 data bytes plus 1 checksum byte.
  - The checksum is the XOR of the 5 data bytes.
  - byte_last is legal only on byte 5.
  - On mismatch, err_format is set, the word is not written (no wr_en), and the state goes to DONE.
  - word_count counts only written words.
- When not defined: 5-byte framing as above, no checksum logic present.

Test Plan:
- Two-word load: start, then bytes 01 02 03 04 05 and 11 22 33 44 55 (last on the final byte) → wr_en at addr 0 data 0x0504030201, wr_en at addr 1 data 0x5544332211, done=1, word_count=2, no errors.
- Backpressure: byte_valid held high through WRITE → byte_ready=0 in WRITE cycles; no byte lost or duplicated; each wr_en exactly one cycle after byte 4 is accepted.
- Format error: byte 4 = 0x85 with last → wr_data[38:32]=0x05, err_format=1, done=1. Separately, last on byte 2 → no write, err_format=1, done=1.
- Overflow: 64 words without last → writes at addr 0..63, then err_overflow=1, done=1, word_count=64, byte_ready=0 afterwards.
- Abort: start pulsed after 3 bytes of word 1 → no write for the partial word; the next full word is written at addr 0 and word_count=1. Separately, reset low mid-load → all outputs 0 asynchronously.
- With INSTR_LOADER_CHECKSUM_EN: 01 02 03 04 05 01 (correct checksum) → written. Same bytes with checksum 00 → no wr_en, err_format=1, done=1.
